comp_result_filter: RTL and testbench

- Downstream stage of the 14-bit magnitude comparator. Consumes its registered 3-bit one-hot result: 3'b001 A<B, 3'b010 A==B, 3'b100 A>B, 3'b000 in reset.
- Applies a persistence (debounce) filter, tracks the filtered relation in a 4-state FSM, and emits change events over a valid/ready handshake.
- Keeps saturating counters of rising (into GT) and falling (into LT) transitions for the control/status logic.

---
 rtl/comp_result_filter.sv | 91 +++++++++
 tb/tb_comp_result_filter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/comp_result_filter.sv
// comp_result_filter: persistence filter on the comparator one-hot result, relation FSM, change events, transition counters.
// Optional: define COMP_FILT_EQ_HOLD_EN to make EQ samples transparent (hysteresis around equality).
module comp_result_filter #(
   parameter int unsigned PERSIST = 4,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             iclk,
   input  logic             irst,
   input  logic [2:0]       comp_in,
   input  logic             clr_cnt,
   output logic [2:0]       state_out,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [5:0]       evt_code,
   output logic             evt_drop,
   output logic [CNT_W-1:0] rise_cnt,
   output logic [CNT_W-1:0] fall_cnt,
   output logic             err_flag
);
   typedef enum logic [2:0] {UNKNOWN = 3'b000, LT = 3'b001, EQ = 3'b010, GT = 3'b100} rel_e;
`ifdef COMP_FILT_EQ_HOLD_EN
   localparam bit EQ_HOLD = 1'b1;
`else
   localparam bit EQ_HOLD = 1'b0;
`endif
   localparam logic [7:0]       PMAX = 8'(PERSIST);
   localparam logic [CNT_W-1:0] CMAX = '1;
   rel_e             state_q;
   logic [7:0]       run_q, run_d, next_run;
   logic [2:0]       cand_q, cand_d;
   logic             evt_valid_q, evt_drop_q, err_q;
   logic [5:0]       evt_code_q;
   logic [CNT_W-1:0] rise_q, fall_q;
   logic             legal, illegal, hold, accept, hs, rise, fall;
   assign hold     = EQ_HOLD && comp_in == EQ;
   assign legal    = comp_in != 3'b000 && (comp_in & (comp_in - 3'd1)) == 3'b000;
   assign illegal  = !legal && comp_in != 3'b000;
   assign next_run = (comp_in == cand_q) ? ((run_q >= PMAX) ? PMAX : run_q + 8'd1) : 8'd1;
   assign accept   = legal && !hold && next_run == PMAX && comp_in != state_q;
   assign hs       = evt_valid_q && evt_ready;
   assign rise     = accept && comp_in == GT && state_q != UNKNOWN;
   assign fall     = accept && comp_in == LT && state_q != UNKNOWN;
   // Idle and illegal samples break the run; transparent EQ leaves it untouched.
   always_comb begin
      run_d  = hold ? run_q : (legal ? next_run : 8'd0);
      cand_d = hold ? cand_q : (legal ? comp_in : 3'b000);
   end
   always_ff @(posedge iclk) begin
      if (irst) begin
         state_q     <= UNKNOWN;
         run_q       <= 8'd0;
         cand_q      <= 3'b000;
         evt_valid_q <= 1'b0;
         evt_code_q  <= 6'd0;
         evt_drop_q  <= 1'b0;
         rise_q      <= '0;
         fall_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         run_q      <= run_d;
         cand_q     <= cand_d;
         evt_drop_q <= accept && evt_valid_q && !evt_ready;
         if (accept)
            state_q <= rel_e'(comp_in);
         if (accept && (!evt_valid_q || evt_ready)) begin
            evt_valid_q <= 1'b1;
            evt_code_q  <= {state_q, comp_in};
         end else if (hs)
            evt_valid_q <= 1'b0;
         if (clr_cnt) begin
            rise_q <= '0;
            fall_q <= '0;
            err_q  <= 1'b0;
         end else begin
            if (rise && rise_q != CMAX)
               rise_q <= rise_q + CNT_W'(1);
            if (fall && fall_q != CMAX)
               fall_q <= fall_q + CNT_W'(1);
            if (illegal)
               err_q <= 1'b1;
         end
      end
   end
   assign state_out = state_q;
   assign evt_valid = evt_valid_q;
   assign evt_code  = evt_code_q;
   assign evt_drop  = evt_drop_q;
   assign rise_cnt  = rise_q;
   assign fall_cnt  = fall_q;
   assign err_flag  = err_q;
endmodule

// File: tb/tb_comp_result_filter.sv
// tb_comp_result_filter: directed vectors with hand-computed expectations, PERSIST=4, CNT_W=2.
module tb_comp_result_filter;
   localparam int CNT_W = 2;
   logic             iclk = 1'b0;
   logic             irst = 1'b1;
   logic [2:0]       comp_in = 3'b000;
   logic             clr_cnt = 1'b0;
   logic             evt_ready = 1'b0;
   logic [2:0]       state_out;
   logic             evt_valid, evt_drop, err_flag;
   logic [5:0]       evt_code;
   logic [CNT_W-1:0] rise_cnt, fall_cnt;
   int               n_chk = 0;
   int               n_fail = 0;
   always #5 iclk = ~iclk;
   comp_result_filter #(.PERSIST(4), .CNT_W(CNT_W)) dut (
      .iclk(iclk), .irst(irst), .comp_in(comp_in), .clr_cnt(clr_cnt),
      .state_out(state_out), .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_code(evt_code), .evt_drop(evt_drop), .rise_cnt(rise_cnt),
      .fall_cnt(fall_cnt), .err_flag(err_flag)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input logic [2:0] c);
      comp_in = c;
      @(posedge iclk);
      #1;
   endtask
   task automatic rep(input logic [2:0] c, input int n);
      for (int i = 0; i < n; i++) step(c);
   endtask
   initial begin
      rep(3'b100, 2);
      irst = 1'b0;
      chk("rst_state", 32'(state_out), 0);
      chk("rst_valid", 32'(evt_valid), 0);
      chk("rst_code", 32'(evt_code), 0);
      chk("rst_err", 32'(err_flag), 0);
      chk("rst_rise", 32'(rise_cnt), 0);
      rep(3'b100, 3);
      chk("gt_3rd", 32'(state_out), 0);
      step(3'b100);
      chk("gt_4th", 32'(state_out), 32'b100);
      chk("gt_valid", 32'(evt_valid), 1);
      chk("gt_code", 32'(evt_code), 32'b000100);
      chk("gt_rise", 32'(rise_cnt), 0);
      evt_ready = 1'b1;
      step(3'b000);
      chk("drain_valid", 32'(evt_valid), 0);
      rep(3'b001, 3);
      chk("lt_three", 32'(state_out), 32'b100);
      step(3'b100);
      rep(3'b001, 3);
      chk("lt_seven", 32'(state_out), 32'b100);
      step(3'b001);
      chk("lt_eighth", 32'(state_out), 32'b001);
      chk("lt_code", 32'(evt_code), 32'b100001);
      chk("lt_fall", 32'(fall_cnt), 1);
      evt_ready = 1'b0;
      rep(3'b100, 4);
      chk("drop_state", 32'(state_out), 32'b100);
      chk("drop_pulse", 32'(evt_drop), 1);
      chk("drop_code", 32'(evt_code), 32'b100001);
      chk("drop_rise", 32'(rise_cnt), 1);
      step(3'b000);
      chk("drop_end", 32'(evt_drop), 0);
      chk("drop_held", 32'(evt_valid), 1);
      evt_ready = 1'b1;
      step(3'b000);
      evt_ready = 1'b0;
      rep(3'b001, 4);
      chk("hold_code", 32'(evt_code), 32'b100001);
      chk("hold_fall", 32'(fall_cnt), 2);
      rep(3'b100, 3);
      evt_ready = 1'b1;
      step(3'b100);
      chk("swap_code", 32'(evt_code), 32'b001100);
      chk("swap_drop", 32'(evt_drop), 0);
      chk("swap_valid", 32'(evt_valid), 1);
      chk("swap_rise", 32'(rise_cnt), 2);
      step(3'b000);
      chk("swap_drain", 32'(evt_valid), 0);
      rep(3'b001, 2);
      step(3'b011);
      chk("ill_err", 32'(err_flag), 1);
      chk("ill_state", 32'(state_out), 32'b100);
      rep(3'b001, 3);
      chk("ill_restart", 32'(state_out), 32'b100);
      step(3'b001);
      chk("ill_accept", 32'(state_out), 32'b001);
      chk("ill_fall", 32'(fall_cnt), 3);
      clr_cnt = 1'b1;
      step(3'b000);
      clr_cnt = 1'b0;
      chk("clr_err", 32'(err_flag), 0);
      chk("clr_fall", 32'(fall_cnt), 0);
      chk("clr_state", 32'(state_out), 32'b001);
      rep(3'b100, 3);
      clr_cnt = 1'b1;
      step(3'b100);
      clr_cnt = 1'b0;
      chk("clrinc_state", 32'(state_out), 32'b100);
      chk("clrinc_rise", 32'(rise_cnt), 0);
      clr_cnt = 1'b1;
      step(3'b111);
      clr_cnt = 1'b0;
      chk("clrill_err", 32'(err_flag), 0);
      step(3'b111);
      chk("ill2_err", 32'(err_flag), 1);
      rep(3'b010, 4);
`ifdef COMP_FILT_EQ_HOLD_EN
      chk("eq_hold", 32'(state_out), 32'b100);
`else
      chk("eq_state", 32'(state_out), 32'b010);
      chk("eq_code", 32'(evt_code), 32'b100010);
      chk("eq_fall", 32'(fall_cnt), 0);
`endif
      rep(3'b100, 4);
      chk("eq_back", 32'(state_out), 32'b100);
      clr_cnt = 1'b1;
      step(3'b000);
      clr_cnt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rep(3'b001, 4);
         rep(3'b100, 4);
      end
      chk("sat_rise", 32'(rise_cnt), 3);
      chk("sat_fall", 32'(fall_cnt), 3);
      evt_ready = 1'b0;
      rep(3'b001, 2);
      chk("pend_valid", 32'(evt_valid), 1);
      irst = 1'b1;
      step(3'b001);
      irst = 1'b0;
      chk("mid_state", 32'(state_out), 0);
      chk("mid_valid", 32'(evt_valid), 0);
      chk("mid_code", 32'(evt_code), 0);
      chk("mid_cnt", 32'({rise_cnt, fall_cnt, err_flag, evt_drop}), 0);
      rep(3'b100, 2);
      step(3'b010);
      step(3'b100);
      chk("eqh_4th", 32'(state_out), 0);
      step(3'b100);
`ifdef COMP_FILT_EQ_HOLD_EN
      chk("eqh_5th", 32'(state_out), 32'b100);
`else
      chk("eqh_5th", 32'(state_out), 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
